// File: rtl/fifo_ser_pkg.sv
// Shared types and defaults for the wide-word FIFO dequeue serializer.
package fifo_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int unsigned DATA_W_DEF = 704;
  localparam int unsigned BEAT_W_DEF = 32;

  function automatic int unsigned beats_of(input int unsigned data_w,
                                           input int unsigned beat_w);
    return data_w / beat_w;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Wide word holding register: parallel load, right shift by one beat, or hold.
module ser_shift_reg #(
  parameter int unsigned DATA_W = 704,
  parameter int unsigned BEAT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [BEAT_W-1:0] beat
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg >> BEAT_W;
    end
  end

  assign beat = shreg[BEAT_W-1:0];

endmodule

// File: rtl/fifo_deq_serializer.sv
// Drains wide words from an upstream FIFO and re-emits each as BEATS narrow
// beats, LSB beat first, reloading on the last beat for zero-bubble streaming.
module fifo_deq_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DATA_W-1:0] in_first,
  input  logic              in_first__RDY,
  input  logic              in_deq__RDY,
  output logic              in_deq__ENA,
  output logic [BEAT_W-1:0] out_enq_v,
  output logic              out_enq_last,
  output logic              out_enq__ENA,
  input  logic              out_enq__RDY,
  output logic              busy
);

  localparam int unsigned BEATS = beats_of(DATA_W, BEAT_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (DATA_W % BEAT_W != 0) begin : g_bad_width
      $error("fifo_deq_serializer: DATA_W must be a multiple of BEAT_W");
    end
  endgenerate

  ser_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             fire;
  logic             lastfire;
  logic             load;
  logic             shift;

  assign take     = in_first__RDY && in_deq__RDY;
  assign fire     = (state == SEND) && out_enq__RDY;
  assign lastfire = fire && (cnt == LAST_CNT);

  // Dequeue is gated by nRST so a reset cycle can never consume an upstream word.
  assign load  = nRST && take && ((state == IDLE) || lastfire);
  assign shift = fire && !lastfire;

  assign in_deq__ENA  = load;
  assign out_enq__ENA = nRST && fire;
  assign out_enq_last = (state == SEND) && (cnt == LAST_CNT);
  assign busy         = (state == SEND);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= SEND;
            cnt   <= '0;
          end
        end
        SEND: begin
          if (lastfire) begin
            cnt   <= '0;
            state <= take ? SEND : IDLE;
          end else if (fire) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  ser_shift_reg #(
    .DATA_W(DATA_W),
    .BEAT_W(BEAT_W)
  ) u_shift (
    .CLK  (CLK),
    .nRST (nRST),
    .load (load),
    .shift(shift),
    .din  (in_first),
    .beat (out_enq_v)
  );

endmodule
